move_sequencer: RTL and testbench

- Sequences the move checker for the falling block.
- Arbitrates between three request sources: spawn (appear), gravity tick and user moves.
- Issues one check at a time and waits for the result. On success it commits the new x/y/rotation; on failure it reports a lock or game-over.
- Sits between the input/timer logic and the move checker. It is the sole owner of the active block's position and rotation registers.

---
 rtl/move_sequencer.sv | 171 +++++++++++++++++
 tb/tb_move_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// Serialises spawn/gravity/user move checks to the move checker and owns the block x/y/rotation.
// Latency: grant->check_run_o 1 cycle, check_done_i->commit 1 cycle; user_ready_o drops while a user move is parked.
// Optional watchdog on the checker response enabled by MOVE_SEQ_TIMEOUT_EN (adds timeout_o).
module move_sequencer #(
  parameter int X_W     = 5,
  parameter int Y_W     = 6,
  parameter int SPAWN_X = 3
`ifdef MOVE_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  appear_i,
  input  logic                  gravity_tick_i,
  input  logic                  user_valid_i,
  input  logic [2:0]            user_move_i,
  output logic                  user_ready_o,
  output logic                  check_run_o,
  output logic [2:0]            check_move_o,
  input  logic                  check_done_i,
  input  logic                  check_can_move_i,
  input  logic [1:0]            check_move_x_i,
  input  logic [1:0]            check_move_y_i,
  output logic signed [X_W-1:0] block_x_o,
  output logic signed [Y_W-1:0] block_y_o,
  output logic [1:0]            rotation_o,
  output logic                  move_done_o,
  output logic                  lock_o,
  output logic                  game_over_o,
  output logic                  busy_o
`ifdef MOVE_SEQ_TIMEOUT_EN
  , output logic                timeout_o
`endif
);

  localparam logic [2:0] MOVE_APPEAR = 3'd0;
  localparam logic [2:0] MOVE_LEFT   = 3'd1;
  localparam logic [2:0] MOVE_RIGHT  = 3'd2;
  localparam logic [2:0] MOVE_DOWN   = 3'd3;
  localparam logic [2:0] MOVE_ROTATE = 3'd4;

  typedef enum logic [1:0] {IDLE, RUN, WAIT, APPLY} state_t;
  state_t state;

  logic       appear_pend, grav_pend, user_pend;
  logic [2:0] user_code;

  logic       user_code_ok, user_acc, appear_req, grav_req, user_req;
  logic [2:0] user_req_code;
  logic       grant_appear, grant_grav, grant_user;
  logic       timeout_hit, resolve, res_can;
  logic signed [X_W-1:0] dx_ext;
  logic signed [Y_W-1:0] dy_ext;

  assign user_ready_o  = rst_n_i & ~user_pend & ~game_over_o;
  assign user_code_ok  = user_move_i inside {MOVE_LEFT, MOVE_RIGHT, MOVE_DOWN, MOVE_ROTATE};
  assign user_acc      = user_valid_i & user_ready_o;
  // Same-cycle pulses join the arbitration so they are served without a stale pending copy.
  assign appear_req    = appear_pend | appear_i;
  assign grav_req      = grav_pend | gravity_tick_i;
  assign user_req      = user_pend | (user_acc & user_code_ok);
  assign user_req_code = user_pend ? user_code : user_move_i;

  assign grant_appear = (state == IDLE) & appear_req;
  assign grant_grav   = (state == IDLE) & ~appear_req & ~game_over_o & grav_req;
  assign grant_user   = (state == IDLE) & ~appear_req & ~game_over_o & ~grav_req & user_req;

  assign busy_o  = (state != IDLE);
  assign resolve = (state == WAIT) & (check_done_i | timeout_hit);
  assign res_can = check_done_i & check_can_move_i;
  assign dx_ext  = {{(X_W-2){check_move_x_i[1]}}, check_move_x_i};
  assign dy_ext  = {{(Y_W-2){check_move_y_i[1]}}, check_move_y_i};

`ifdef MOVE_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  logic [CW-1:0] wait_cnt;
  assign timeout_hit = (wait_cnt == CW'(TIMEOUT_CYC - 1)) & ~check_done_i;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      appear_pend  <= 1'b0;
      grav_pend    <= 1'b0;
      user_pend    <= 1'b0;
      user_code    <= MOVE_APPEAR;
      check_run_o  <= 1'b0;
      check_move_o <= MOVE_APPEAR;
      block_x_o    <= X_W'(SPAWN_X);
      block_y_o    <= '0;
      rotation_o   <= 2'd0;
      move_done_o  <= 1'b0;
      lock_o       <= 1'b0;
      game_over_o  <= 1'b0;
`ifdef MOVE_SEQ_TIMEOUT_EN
      wait_cnt     <= '0;
      timeout_o    <= 1'b0;
`endif
    end else begin
      check_run_o <= 1'b0;
      move_done_o <= 1'b0;
      lock_o      <= 1'b0;
`ifdef MOVE_SEQ_TIMEOUT_EN
      timeout_o   <= 1'b0;
`endif
      appear_pend <= grant_appear ? 1'b0 : appear_req;
      grav_pend   <= grant_grav ? 1'b0 : grav_req;
      if (grant_user) begin
        user_pend <= 1'b0;
      end else if (user_acc && user_code_ok) begin
        user_pend <= 1'b1;
        user_code <= user_move_i;
      end

      case (state)
        IDLE: begin
          if (grant_appear) begin
            block_x_o    <= X_W'(SPAWN_X);
            block_y_o    <= '0;
            rotation_o   <= 2'd0;
            game_over_o  <= 1'b0;
            check_move_o <= MOVE_APPEAR;
            check_run_o  <= 1'b1;
            state        <= RUN;
          end else if (grant_grav) begin
            check_move_o <= MOVE_DOWN;
            check_run_o  <= 1'b1;
            state        <= RUN;
          end else if (grant_user) begin
            check_move_o <= user_req_code;
            check_run_o  <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          state <= WAIT;
`ifdef MOVE_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
`ifdef MOVE_SEQ_TIMEOUT_EN
          wait_cnt <= wait_cnt + 1'b1;
          timeout_o <= timeout_hit;
`endif
          // Commit on the resolving edge so outputs land one cycle after check_done_i.
          if (resolve) begin
            move_done_o <= 1'b1;
            state       <= APPLY;
            if (res_can) begin
              if (check_move_o != MOVE_APPEAR) begin
                block_x_o <= block_x_o + dx_ext;
                block_y_o <= block_y_o + dy_ext;
              end
              if (check_move_o == MOVE_ROTATE) rotation_o <= rotation_o + 2'd1;
            end else begin
              if (check_move_o == MOVE_DOWN)   lock_o      <= 1'b1;
              if (check_move_o == MOVE_APPEAR) game_over_o <= 1'b1;
            end
          end
        end
        APPLY: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: a behavioural checker answers each check_run_o with a scripted verdict.
module tb_move_sequencer;

  localparam logic [2:0] MOVE_APPEAR = 3'd0;
  localparam logic [2:0] MOVE_LEFT   = 3'd1;
  localparam logic [2:0] MOVE_RIGHT  = 3'd2;
  localparam logic [2:0] MOVE_DOWN   = 3'd3;
  localparam logic [2:0] MOVE_ROTATE = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       appear = 1'b0, gravity = 1'b0, user_valid = 1'b0;
  logic [2:0] user_move = 3'd0;
  logic       user_ready, check_run, check_done = 1'b0, check_can = 1'b0;
  logic [2:0] check_move;
  logic [1:0] dx = 2'd0, dy = 2'd0;
  logic signed [4:0] block_x;
  logic signed [5:0] block_y;
  logic [1:0] rotation;
  logic       move_done, lock, game_over, busy;

  int n_cmp = 0;
  int n_bad = 0;

  move_sequencer dut (
    .clk_i(clk), .rst_n_i(rst_n), .appear_i(appear), .gravity_tick_i(gravity),
    .user_valid_i(user_valid), .user_move_i(user_move), .user_ready_o(user_ready),
    .check_run_o(check_run), .check_move_o(check_move), .check_done_i(check_done),
    .check_can_move_i(check_can), .check_move_x_i(dx), .check_move_y_i(dy),
    .block_x_o(block_x), .block_y_o(block_y), .rotation_o(rotation),
    .move_done_o(move_done), .lock_o(lock), .game_over_o(game_over), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Wait (bounded) for the start pulse, then answer one cycle into WAIT; returns in the APPLY cycle.
  task automatic serve(input logic [2:0] code, input logic can, input logic [1:0] mx, input logic [1:0] my);
    int n = 0;
    while (!check_run && n < 20) begin
      step();
      n++;
    end
    chk("run_seen", int'(check_run), 1);
    chk("run_code", int'(check_move), int'(code));
    step();
    chk("run_one_cycle", int'(check_run), 0);
    check_done = 1'b1; check_can = can; dx = mx; dy = my;
    step();
    check_done = 1'b0; check_can = 1'b0; dx = 2'd0; dy = 2'd0;
    chk("move_done", int'(move_done), 1);
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_x", int'(block_x), 3);
    chk("rst_y", int'(block_y), 0);
    chk("rst_rot", int'(rotation), 0);
    chk("rst_ready", int'(user_ready), 0);
    chk("rst_gover", int'(game_over), 0);
    chk("rst_run", int'(check_run), 0);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", int'(user_ready), 1);

    // Spawn, check_run one cycle after grant
    appear = 1'b1; step(); appear = 1'b0;
    chk("appear_lat", int'(check_run), 1);
    serve(MOVE_APPEAR, 1'b1, 2'd0, 2'd0);
    chk("appear_x", int'(block_x), 3);
    chk("appear_y", int'(block_y), 0);
    chk("appear_rot", int'(rotation), 0);
    step();
    chk("done_single", int'(move_done), 0);
    chk("idle_after", int'(busy), 0);

    // User LEFT with dx = -1
    user_valid = 1'b1; user_move = MOVE_LEFT; step(); user_valid = 1'b0;
    serve(MOVE_LEFT, 1'b1, 2'b11, 2'd0);
    chk("left_x", int'(block_x), 2);
    step();

    // Four rotations wrap 1,2,3,0
    for (int i = 0; i < 4; i++) begin
      user_valid = 1'b1; user_move = MOVE_ROTATE; step(); user_valid = 1'b0;
      serve(MOVE_ROTATE, 1'b1, 2'd0, 2'd0);
      chk("rot_seq", int'(rotation), (i + 1) % 4);
      step();
    end

    // Gravity and RIGHT together: DOWN first, RIGHT parked
    gravity = 1'b1; user_valid = 1'b1; user_move = MOVE_RIGHT; step();
    gravity = 1'b0; user_valid = 1'b0;
    chk("slot_full_ready", int'(user_ready), 0);
    serve(MOVE_DOWN, 1'b1, 2'd0, 2'd1);
    chk("down_y", int'(block_y), 1);
    chk("slot_still_full", int'(user_ready), 0);
    step();
    serve(MOVE_RIGHT, 1'b1, 2'd1, 2'd0);
    chk("right_x", int'(block_x), 3);
    chk("slot_drained", int'(user_ready), 1);
    step();

    // Failed gravity locks
    gravity = 1'b1; step(); gravity = 1'b0;
    serve(MOVE_DOWN, 1'b0, 2'd0, 2'd1);
    chk("lock_pulse", int'(lock), 1);
    chk("lock_y", int'(block_y), 1);
    step();
    chk("lock_single", int'(lock), 0);

    // Failed appear -> game over, grants blocked
    appear = 1'b1; step(); appear = 1'b0;
    serve(MOVE_APPEAR, 1'b0, 2'd0, 2'd0);
    chk("gover_set", int'(game_over), 1);
    chk("gover_ready", int'(user_ready), 0);
    chk("gover_y", int'(block_y), 0);
    step();
    gravity = 1'b1; step(); gravity = 1'b0;
    step(); step();
    chk("gover_blocks", int'(busy), 0);

    // Appear restarts, then reset in WAIT and a late done
    appear = 1'b1; step(); appear = 1'b0;
    chk("gover_clear", int'(game_over), 0);
    step();
    chk("in_wait", int'(busy), 1);
    rst_n = 1'b0; step();
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(user_ready), 0);
    rst_n = 1'b1;
    check_done = 1'b1; check_can = 1'b1; dx = 2'd1; dy = 2'd1;
    step();
    check_done = 1'b0; check_can = 1'b0; dx = 2'd0; dy = 2'd0;
    chk("late_done", int'(move_done), 0);
    chk("late_x", int'(block_x), 3);
    chk("late_y", int'(block_y), 0);
    step();
    chk("late_idle", int'(busy), 0);

    // Unknown code is accepted and dropped
    user_valid = 1'b1; user_move = 3'd7; step(); user_valid = 1'b0;
    chk("bad_code_run", int'(check_run), 0);
    step();
    chk("bad_code_idle", int'(busy), 0);
    chk("bad_code_ready", int'(user_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
